// File: rtl/mmio_stream_port.sv
// mmio_stream_port
//   Device-side endpoint of one MMIO port slot. CPU writes are queued in a TX
//   FIFO and drained over a valid/ready stream; words arriving on an input
//   valid/ready stream are queued in an RX FIFO and popped by CPU reads.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   port_wdata/wctrl    CPU data and control words, qualified by port_inform_write
//   port_inform_write   one-cycle pulse: CPU wrote the port
//   port_inform_read    one-cycle pulse: CPU read the port (pops RX head)
//   port_rdata          RX head word, 0 when RX is empty
//   port_status         {rx_ne, tx_full, rx_ovf, tx_ovf, 4'b0, rx_count, tx_count}
//   tx_valid/data/ready outbound stream fed by the TX FIFO
//   rx_valid/data/ready inbound stream feeding the RX FIFO
module mmio_stream_port #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_wdata,
    input  logic [15:0] port_wctrl,
    input  logic        port_inform_write,
    input  logic        port_inform_read,
    output logic [15:0] port_rdata,
    output logic [15:0] port_status,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [15:0]      tx_mem_q [DEPTH];
    logic [15:0]      rx_mem_q [DEPTH];
    logic [PTR_W-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PTR_W-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [3:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic             tx_ovf_q, tx_ovf_d;

    logic is_cmd, flush_tx, flush_rx, clr_flags, push_req;
    logic tx_full, tx_pop, tx_push, tx_ovf_set;
    logic rx_empty, rx_push, rx_pop;

    // Any of the low three control bits turns the write into a command;
    // command writes never push data.
    assign is_cmd    = port_inform_write & (|port_wctrl[2:0]);
    assign flush_tx  = is_cmd & port_wctrl[0];
    assign flush_rx  = is_cmd & port_wctrl[1];
    assign clr_flags = is_cmd & port_wctrl[2];
    assign push_req  = port_inform_write & ~is_cmd;

    assign tx_full    = (tx_cnt_q == DEPTH_C);
    assign tx_valid   = (tx_cnt_q != 4'd0);
    assign tx_pop     = tx_valid & tx_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign tx_push    = push_req & (~tx_full | tx_pop);
    assign tx_ovf_set = push_req & tx_full & ~tx_pop;

    assign rx_empty = (rx_cnt_q == 4'd0);
    assign rx_ready = (rx_cnt_q < DEPTH_C);
    assign rx_push  = rx_valid & rx_ready & ~flush_rx;
    assign rx_pop   = port_inform_read & ~rx_empty;

    assign tx_data    = tx_valid ? tx_mem_q[tx_rp_q] : 16'h0000;
    assign port_rdata = rx_empty ? 16'h0000 : rx_mem_q[rx_rp_q];

    // rx_ovf (bit 13) cannot be set while rx_ready gates every push; held at 0.
    assign port_status = {~rx_empty, tx_full, 1'b0, tx_ovf_q, 4'b0000, rx_cnt_q, tx_cnt_q};

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;

        if (flush_tx) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = 4'd0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + PTR_W'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + PTR_W'(1);
            tx_cnt_d = tx_cnt_q + 4'(tx_push) - 4'(tx_pop);
        end

        if (flush_rx) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = 4'd0;
        end else begin
            if (rx_push) rx_wp_d = rx_wp_q + PTR_W'(1);
            if (rx_pop)  rx_rp_d = rx_rp_q + PTR_W'(1);
            rx_cnt_d = rx_cnt_q + 4'(rx_push) - 4'(rx_pop);
        end

        // A new overflow on the same edge as a clear leaves the flag set.
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= 4'd0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= 4'd0;
            tx_ovf_q <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= 16'h0000;
                rx_mem_q[i] <= 16'h0000;
            end
        end else begin
            if (tx_push) tx_mem_q[tx_wp_q] <= port_wdata;
            if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_mmio_stream_port.sv
module tb_mmio_stream_port;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] port_wdata = '0;
    logic [15:0] port_wctrl = '0;
    logic        port_inform_write = 1'b0;
    logic        port_inform_read = 1'b0;
    logic [15:0] port_rdata;
    logic [15:0] port_status;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_ready;

    mmio_stream_port #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .port_wdata(port_wdata), .port_wctrl(port_wctrl),
        .port_inform_write(port_inform_write), .port_inform_read(port_inform_read),
        .port_rdata(port_rdata), .port_status(port_status),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain queues plus the sticky TX overflow flag.
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic        m_tx_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_status();
        int s;
        s = 0;
        if (rxq.size() != 0)    s += 32768;
        if (txq.size() == DEPTH) s += 16384;
        if (m_tx_ovf)           s += 4096;
        s += rxq.size() * 16 + txq.size();
        return 16'(s);
    endfunction

    task automatic compare_outputs();
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() != 0});
        if (txq.size() != 0) chk("tx_data", {16'b0, tx_data}, {16'b0, txq[0]});
        chk("rx_ready", {31'b0, rx_ready}, {31'b0, rxq.size() < DEPTH});
        chk("port_rdata", {16'b0, port_rdata}, {16'b0, (rxq.size() != 0) ? rxq[0] : 16'h0000});
        chk("port_status", {16'b0, port_status}, {16'b0, model_status()});
    endtask

    task automatic model_update();
        bit cmd, tx_pop, rx_push, rx_pop;
        cmd     = port_inform_write && (port_wctrl[2:0] != 3'b000);
        tx_pop  = tx_ready && (txq.size() != 0);
        rx_push = rx_valid && (rxq.size() < DEPTH);
        rx_pop  = port_inform_read && (rxq.size() != 0);
        if (tx_pop) void'(txq.pop_front());
        if (cmd) begin
            if (port_wctrl[0]) txq.delete();
            if (port_wctrl[2]) m_tx_ovf = 1'b0;
        end else if (port_inform_write) begin
            if (txq.size() < DEPTH) txq.push_back(port_wdata);
            else m_tx_ovf = 1'b1;
        end
        if (cmd && port_wctrl[1]) begin
            rxq.delete();
        end else begin
            if (rx_pop)  void'(rxq.pop_front());
            if (rx_push) rxq.push_back(rx_data);
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising
    // edge using the inputs currently applied, then leave 1 time unit for the
    // caller to change inputs.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        port_inform_write = 1'b0;
        port_inform_read  = 1'b0;
        port_wctrl        = 16'h0000;
        rx_valid          = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        // Reset
        idle_inputs();
        #12;
        chk("rst tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst tx_data", {16'b0, tx_data}, 32'h0);
        chk("rst rx_ready", {31'b0, rx_ready}, 32'd1);
        chk("rst port_rdata", {16'b0, port_rdata}, 32'h0);
        chk("rst port_status", {16'b0, port_status}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single write
        tx_ready = 1'b0;
        port_inform_write = 1'b1; port_wctrl = 16'h0000; port_wdata = 16'hA5A5;
        step();
        idle_inputs();
        chk("t1 tx_valid", {31'b0, tx_valid}, 32'd1);
        chk("t1 tx_data", {16'b0, tx_data}, 32'hA5A5);
        chk("t1 tx_count", {28'b0, port_status[3:0]}, 32'd1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;

        // 2: fill 1..8, 9th overflows
        for (int i = 1; i <= 9; i++) begin
            port_inform_write = 1'b1; port_wdata = 16'(i);
            step();
        end
        idle_inputs();
        chk("t2 tx_full", {31'b0, port_status[14]}, 32'd1);
        chk("t2 tx_ovf", {31'b0, port_status[12]}, 32'd1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("t2 drain order", {16'b0, tx_data}, i);
            step();
        end
        chk("t2 no ninth", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // 3: full + simultaneous pop accepts the push
        port_inform_write = 1'b1; port_wctrl = 16'h0004;
        step();
        port_wctrl = 16'h0000;
        for (int i = 1; i <= 8; i++) begin
            port_wdata = 16'h0010 + 16'(i);
            step();
        end
        tx_ready = 1'b1; port_wdata = 16'h00FF;
        step();
        idle_inputs();
        chk("t3 count", {28'b0, port_status[3:0]}, 32'd8);
        chk("t3 no ovf", {31'b0, port_status[12]}, 32'd0);
        for (int i = 0; i < 7; i++) step();
        chk("t3 last word", {16'b0, tx_data}, 32'h00FF);
        step();
        tx_ready = 1'b0;

        // 4: RX stream in, CPU reads out
        rx_valid = 1'b1; rx_data = 16'h1234;
        step();
        rx_data = 16'h5678;
        step();
        rx_valid = 1'b0;
        chk("t4 rdata0", {16'b0, port_rdata}, 32'h1234);
        port_inform_read = 1'b1;
        step();
        chk("t4 rdata1", {16'b0, port_rdata}, 32'h5678);
        step();
        port_inform_read = 1'b0;
        chk("t4 rdata2", {16'b0, port_rdata}, 32'h0);
        chk("t4 rx_ne", {31'b0, port_status[15]}, 32'd0);
        port_inform_read = 1'b1;
        step();
        port_inform_read = 1'b0;

        // 5: flush both + clear while RX word arrives
        for (int i = 0; i < 3; i++) begin
            port_inform_write = 1'b1; port_wdata = 16'h0100 + 16'(i);
            rx_valid = 1'b1; rx_data = 16'h0200 + 16'(i);
            step();
        end
        port_wctrl = 16'h0007; rx_data = 16'hBEEF; port_wdata = 16'hDEAD;
        step();
        idle_inputs();
        chk("t5 status", {16'b0, port_status}, 32'h0);
        chk("t5 tx_valid", {31'b0, tx_valid}, 32'd0);
        step();

        // 6: reset mid-drain
        for (int i = 0; i < 3; i++) begin
            port_inform_write = 1'b1; port_wdata = 16'h0300 + 16'(i);
            rx_valid = 1'b1; rx_data = 16'h0400 + 16'(i);
            step();
        end
        idle_inputs();
        tx_ready = 1'b1;
        step();
        chk("t6 pre tx_valid", {31'b0, tx_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6 tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("t6 status", {16'b0, port_status}, 32'h0);
        chk("t6 rx_ready", {31'b0, rx_ready}, 32'd1);
        txq.delete(); rxq.delete(); m_tx_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int blk = 0; blk < 12; blk++) begin
            int p_wr, p_rd, p_txr, p_rxv;
            p_wr  = $urandom_range(10, 90);
            p_rd  = $urandom_range(10, 90);
            p_txr = $urandom_range(5, 95);
            p_rxv = $urandom_range(10, 90);
            for (int c = 0; c < 250; c++) begin
                port_inform_write = ($urandom_range(0, 99) < p_wr);
                port_inform_read  = ($urandom_range(0, 99) < p_rd);
                tx_ready          = ($urandom_range(0, 99) < p_txr);
                rx_valid          = ($urandom_range(0, 99) < p_rxv);
                port_wdata        = 16'($urandom);
                rx_data           = 16'($urandom);
                w = 16'($urandom);
                if ($urandom_range(0, 19) == 0) begin
                    if (w[2:0] == 3'b000) w[2] = 1'b1;
                end else begin
                    w[2:0] = 3'b000;
                end
                port_wctrl = w;
                step();
            end
        end

        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
